hwpe_stream_fifo_lvl: RTL and testbench

Parametrised successor of the baseline HWPE stream FIFO, with these additions:
- non-power-of-two depth;
- an explicit occupancy counter;
- run-time almost-full and almost-empty thresholds;
- an optional zero-latency fall-through mode.

It sits between HWPE streamers and engine datapaths wherever back-pressure hysteresis or fill-level monitoring is needed. It uses the standard `hwpe_stream_intf_stream` handshake.

---
 rtl/hwpe_stream_fifo_lvl_pkg.sv | 15 +
 rtl/hwpe_stream_fifo_lvl_if.sv | 13 +
 rtl/hwpe_stream_fifo_lvl.sv | 116 +++++++++++
 tb/tb_hwpe_stream_fifo_lvl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/hwpe_stream_fifo_lvl_pkg.sv
// Shared types for the level-monitoring HWPE stream FIFO.
// The flags struct carries the fill level, sized for the deepest supported FIFO.
package hwpe_stream_fifo_lvl_pkg;

  localparam int unsigned HWPE_STREAM_FIFO_LVL_MAX_W = 16;

  typedef struct packed {
    logic                                  empty;
    logic                                  full;
    logic                                  almost_empty;
    logic                                  almost_full;
    logic [HWPE_STREAM_FIFO_LVL_MAX_W-1:0] level;
  } flags_fifo_lvl_t;

endpackage

// File: rtl/hwpe_stream_fifo_lvl_if.sv
// HWPE stream handshake: payload (data/strb) qualified by valid, throttled by ready.
// The master drives the payload; the slave drives ready.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport master (output valid, data, strb, input ready);
  modport slave  (input valid, data, strb, output ready);
endinterface

// File: rtl/hwpe_stream_fifo_lvl.sv
// Stream FIFO with arbitrary depth, occupancy counter, run-time almost-full/empty
// thresholds and an optional zero-latency fall-through path when empty.
module hwpe_stream_fifo_lvl
  import hwpe_stream_fifo_lvl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned FALL_THROUGH = 0
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              clear_i,
  input  logic [$clog2(FIFO_DEPTH+1)-1:0]   af_thr_i,
  input  logic [$clog2(FIFO_DEPTH+1)-1:0]   ae_thr_i,
  output flags_fifo_lvl_t                   flags_o,
  hwpe_stream_intf_stream.slave             push_i,
  hwpe_stream_intf_stream.master            pop_o
);

  localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH+1);
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned STRB_W  = DATA_WIDTH/8;
  localparam int unsigned ENTRY_W = DATA_WIDTH + STRB_W;

  localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH-1);

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   count_q,  count_d;
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];

  logic               empty;
  logic               ft_empty;
  logic               pop_valid;
  logic               bypass;
  logic               push_xfer;
  logic               pop_xfer;
  logic [ENTRY_W-1:0] pop_entry;

  assign empty     = (count_q == '0);
  assign ft_empty  = (FALL_THROUGH != 0) && empty;
  assign pop_valid = ft_empty ? push_i.valid : !empty;

  // A bypassed beat never touches storage, so it must not count as a push.
  assign bypass    = ft_empty && push_i.valid && pop_o.ready;
  assign push_xfer = push_i.valid && push_i.ready && !bypass;
  assign pop_xfer  = pop_valid && pop_o.ready && !empty;

  assign push_i.ready = (count_q != DEPTH_L);
  assign pop_o.valid  = pop_valid;

  always_comb begin
    pop_entry = '0;
    if (pop_valid) begin
      pop_entry = ft_empty ? {push_i.data, push_i.strb} : mem_q[rd_ptr_q];
    end
  end

  assign pop_o.data = pop_entry[ENTRY_W-1:STRB_W];
  assign pop_o.strb = pop_entry[STRB_W-1:0];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_xfer) begin
        wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop_xfer) begin
        rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      if (push_xfer && !pop_xfer) begin
        count_d = count_q + LVL_W'(1);
      end else if (!push_xfer && pop_xfer) begin
        count_d = count_q - LVL_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately unreset; clear only rewinds the pointers.
  always_ff @(posedge clk_i) begin
    if (push_xfer && !clear_i) begin
      mem_q[wr_ptr_q] <= {push_i.data, push_i.strb};
    end
  end

  always_comb begin
    flags_o              = '0;
    flags_o.empty        = empty;
    flags_o.full         = (count_q == DEPTH_L);
    flags_o.almost_full  = (count_q >= af_thr_i);
    flags_o.almost_empty = (count_q <= ae_thr_i);
    flags_o.level        = HWPE_STREAM_FIFO_LVL_MAX_W'(count_q);
  end

  count_le_depth: assert property (@(posedge clk_i) disable iff (!rst_ni) count_q <= DEPTH_L);

endmodule

// File: tb/tb_hwpe_stream_fifo_lvl.sv
// Drives a registered and a fall-through FIFO with identical stimulus; a queue
// model predicts handshakes/flags and a per-instance monitor scores popped beats.
module tb_hwpe_stream_fifo_lvl;
  import hwpe_stream_fifo_lvl_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned SW    = DW/8;
  localparam int unsigned DEPTH = 5;
  localparam int unsigned LW    = $clog2(DEPTH+1);

  typedef logic [DW+SW-1:0] beat_t;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_pv  = 1'b0;
  logic          s_pr  = 1'b0;
  logic          s_clr = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic [SW-1:0] s_strb = '0;
  logic [LW-1:0] s_af   = LW'(4);
  logic [LW-1:0] s_ae   = LW'(1);

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst=%0d t=%0t got=%0h want=%0h", name, inst, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gi
    hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) push_if ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) pop_if ();
    flags_fifo_lvl_t flags;
    beat_t mdl[$];
    beat_t sb[$];

    assign push_if.valid = s_pv;
    assign push_if.data  = s_data;
    assign push_if.strb  = s_strb;
    assign pop_if.ready  = s_pr;

    hwpe_stream_fifo_lvl #(
      .DATA_WIDTH  (DW),
      .FIFO_DEPTH  (DEPTH),
      .FALL_THROUGH(g)
    ) dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .clear_i (s_clr),
      .af_thr_i(s_af),
      .ae_thr_i(s_ae),
      .flags_o (flags),
      .push_i  (push_if),
      .pop_o   (pop_if)
    );

    // Reference model: contents are a plain queue; level is its size.
    always @(negedge clk) begin
      int    lvl;
      bit    ft_empty, e_valid, e_ready, bypass, do_push, do_pop;
      beat_t beat;
      #1;
      if (!rst_n) begin
        mdl.delete();
        sb.delete();
      end
      lvl      = mdl.size();
      beat     = {s_data, s_strb};
      ft_empty = (g == 1) && (lvl == 0);
      e_ready  = (lvl != DEPTH);
      e_valid  = ft_empty ? s_pv : (lvl != 0);

      chk("push_ready",   g, push_if.ready,       e_ready);
      chk("pop_valid",    g, pop_if.valid,        e_valid);
      chk("empty",        g, flags.empty,         lvl == 0);
      chk("full",         g, flags.full,          lvl == DEPTH);
      chk("almost_empty", g, flags.almost_empty,  lvl <= int'(s_ae));
      chk("almost_full",  g, flags.almost_full,   lvl >= int'(s_af));
      chk("level",        g, flags.level,         lvl);
      if (!e_valid) chk("idle_payload", g, {pop_if.data, pop_if.strb}, 0);

      if (!rst_n || s_clr) begin
        mdl.delete();
        sb.delete();
      end else begin
        bypass  = ft_empty && s_pv && s_pr;
        do_push = s_pv && e_ready && !bypass;
        do_pop  = e_valid && s_pr && (lvl != 0);
        if (bypass) sb.push_back(beat);
        if (do_pop) void'(mdl.pop_front());
        if (do_push) begin
          mdl.push_back(beat);
          sb.push_back(beat);
        end
      end
    end

    // Monitor: every handshake on the pop side must deliver the oldest expected beat.
    always @(negedge clk) begin
      beat_t exp_b;
      #2;
      if (rst_n && !s_clr && pop_if.valid && pop_if.ready) begin
        if (sb.size() == 0) begin
          chk("pop_unexpected", g, pop_if.valid, 0);
        end else begin
          exp_b = sb.pop_front();
          chk("pop_data", g, {pop_if.data, pop_if.strb}, exp_b);
        end
      end
    end
  end

  task automatic drive(input bit pv, input bit pr, input bit clr, input logic [DW-1:0] d);
    @(negedge clk);
    s_pv   = pv;
    s_pr   = pr;
    s_clr  = clr;
    s_data = d;
    s_strb = SW'($urandom_range(0, 15));
  endtask

  initial begin
    int pr_pct;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Fill past capacity, then drain in order.
    for (int i = 0; i < 7; i++) drive(1, 0, 0, 32'hD0 + DW'(i));
    for (int i = 0; i < 6; i++) drive(0, 1, 0, '0);

    // Streaming with toggling pop ready; pointers wrap.
    for (int i = 0; i < 12; i++) drive(1, (i % 2) == 0, 0, 32'h200 + DW'(i));
    for (int i = 0; i < 7; i++) drive(0, 1, 0, '0);

    // Threshold crossings and a same-cycle threshold change at level 3.
    s_af = LW'(4);
    s_ae = LW'(1);
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 32'h300 + DW'(i));
      if (i == 3) s_af = LW'(2);
    end
    for (int i = 0; i < 6; i++) drive(0, 1, 0, '0);
    s_af = LW'(0);
    drive(0, 1, 0, '0);
    s_af = LW'(4);

    // Empty FIFO: bypass with ready high, store with ready low.
    drive(1, 1, 0, 32'hA5A5A5A5);
    drive(1, 0, 0, 32'hA5A5A5A5);
    drive(0, 1, 0, '0);
    drive(0, 1, 0, '0);

    // Clear at level 3 together with push and pop.
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 32'h400 + DW'(i));
    drive(1, 1, 1, 32'h77);
    drive(0, 0, 0, '0);
    drive(1, 0, 0, 32'h11);
    drive(0, 1, 0, '0);
    drive(0, 1, 0, '0);

    // Asynchronous reset while holding four beats and transferring.
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 32'h500 + DW'(i));
    drive(1, 1, 0, 32'h504);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    s_pv  = 1'b0;
    s_pr  = 1'b0;
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 32'h600 + DW'(i));
    for (int i = 0; i < 4; i++) drive(0, 1, 0, '0);

    // Randomised phases alternating between draining and filling pressure.
    for (int i = 0; i < 600; i++) begin
      pr_pct = ((i / 100) % 2 == 1) ? 30 : 80;
      if (i % 16 == 0) begin
        s_af = LW'($urandom_range(0, 7));
        s_ae = LW'($urandom_range(0, 7));
      end
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 99) < pr_pct,
            $urandom_range(0, 40) == 0, $urandom);
    end
    for (int i = 0; i < 8; i++) drive(0, 1, 0, '0);

    @(negedge clk);
    #5;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
